// File: rtl/control_watchdog.sv
// control_watchdog
// Keep-alive supervisor for the control byte stream. The upstream controller
// must deliver SIGNATURE at least once every TIMEOUT_TICKS cycles while the
// watchdog is enabled. If it does not, reset_out is driven high for
// RESET_PULSE_CYCLES cycles and the saturating timeout_count is bumped.
// The signature matcher runs in every state except FIRE, so fed can pulse
// even while the watchdog is disabled.
module control_watchdog #(
    parameter int                        SIGNATURE_BITS     = 64,
    parameter logic [SIGNATURE_BITS-1:0] SIGNATURE          = 64'hDEAD_BEEF_FEEB_DAED,
    parameter int                        TIMEOUT_TICKS      = 1_000_000,
    parameter int                        RESET_PULSE_CYCLES = 16
) (
    input  logic       clk_root,
    input  logic       reset,
    input  logic       enable,
    input  logic       data_valid,
    input  logic [7:0] data,
    output logic       fed,
    output logic       reset_out,
    output logic [7:0] timeout_count
);

    localparam int CNT_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam int PULSE_W = $clog2(RESET_PULSE_CYCLES + 1);

    localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(RESET_PULSE_CYCLES);
    localparam logic [PULSE_W-1:0] PULSE_ONE  = PULSE_W'(1);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FIRE     = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          countdown_q, countdown_d;
    logic [PULSE_W-1:0]        pulse_q, pulse_d;
    logic [SIGNATURE_BITS-1:0] shift_q, shift_d;
    logic [SIGNATURE_BITS-1:0] shift_in;
    logic                      match;
    logic                      fed_d;
    logic                      reset_out_d;
    logic [7:0]                timeout_count_d;

    // Candidate shift value if the current byte is accepted; the match is
    // judged against this value so fed lands one cycle after the final byte.
    assign shift_in = {shift_q[SIGNATURE_BITS-9:0], data};
    assign match    = (state_q != ST_FIRE) && data_valid && (shift_in == SIGNATURE);

    // Next-state, countdown, pulse counter, matcher and output decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        state_d         = state_q;
        countdown_d     = countdown_q;
        pulse_d         = pulse_q;
        shift_d         = shift_q;
        timeout_count_d = timeout_count;
        reset_out_d     = 1'b0;
        fed_d           = match;

        // A match clears the shifter so trailing bytes cannot re-match.
        if ((state_q != ST_FIRE) && data_valid) begin
            shift_d = match ? '0 : shift_in;
        end

        case (state_q)
            ST_DISABLED: begin
                countdown_d = CNT_LOAD;
                if (enable) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (!enable) begin
                    state_d     = ST_DISABLED;
                    countdown_d = CNT_LOAD;
                end else if (match) begin
                    // A feed on the expiry cycle still wins.
                    countdown_d = CNT_LOAD;
                end else if (countdown_q == CNT_ONE) begin
                    state_d     = ST_FIRE;
                    pulse_d     = PULSE_LOAD;
                    reset_out_d = 1'b1;
                    if (timeout_count != 8'hFF) begin
                        timeout_count_d = timeout_count + 8'd1;
                    end
                end else begin
                    countdown_d = countdown_q - CNT_ONE;
                end
            end

            ST_FIRE: begin
                // Bytes are dropped during the pulse and enable cannot cut it short.
                shift_d = '0;
                if (pulse_q == PULSE_ONE) begin
                    countdown_d = CNT_LOAD;
                    state_d     = enable ? ST_ARMED : ST_DISABLED;
                end else begin
                    pulse_d     = pulse_q - PULSE_ONE;
                    reset_out_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_DISABLED;
                countdown_d = CNT_LOAD;
                shift_d     = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk_root) begin
        if (reset) begin
            // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
            state_q       <= ST_DISABLED;
            countdown_q   <= CNT_LOAD;
            pulse_q       <= '0;
            shift_q       <= '0;
            fed           <= 1'b0;
            reset_out     <= 1'b0;
            timeout_count <= 8'd0;
        end else begin
            state_q       <= state_d;
            countdown_q   <= countdown_d;
            pulse_q       <= pulse_d;
            shift_q       <= shift_d;
            fed           <= fed_d;
            reset_out     <= reset_out_d;
            timeout_count <= timeout_count_d;
        end
    end

endmodule
